// File: rtl/uart_nand_pkg.sv
// Shared definitions for the UART-to-NAND command bridge.
//   state_e     : bridge FSM states
//   CH_* / RSP_*: ASCII command and response bytes
//   UART_EMPTY  : value simpleuart returns on reg_dat_do when its RX FIFO is empty
package uart_nand_pkg;

    typedef enum logic [3:0] {
        StBoot,
        StIdle,
        StRxPop,
        StDispatch,
        StArgWait,
        StArgPop,
        StNandGo,
        StNandHi,
        StNandLo,
        StTx
    } state_e;

    localparam logic [7:0] CH_C     = 8'h43;  // 'C'
    localparam logic [7:0] CH_D     = 8'h44;  // 'D'
    localparam logic [7:0] CH_R     = 8'h52;  // 'R'
    localparam logic [7:0] CH_L     = 8'h4C;  // 'L'
    localparam logic [7:0] CH_S     = 8'h53;  // 'S'
    localparam logic [7:0] RSP_K    = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_Q    = 8'h3F;  // '?'
    localparam logic [7:0] RSP_T    = 8'h54;  // 'T'
    localparam logic [7:0] RSP_E    = 8'h45;  // 'E'
    localparam logic [7:0] RSP_B    = 8'h42;  // 'B'
    localparam logic [7:0] RSP_P    = 8'h50;  // 'P'
    localparam logic [7:0] RSP_ZERO = 8'h30;  // '0'

    localparam logic [31:0] UART_EMPTY = 32'hFFFF_FFFF;

    // True for ASCII '0'..'7', the valid LED arguments.
    function automatic logic is_led_digit(logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h37);
    endfunction

endpackage

// File: rtl/uart_tx_holder.sv
// Holds a TX byte and the UART write strobe until simpleuart accepts it.
//   clk_i, rst_ni : clock, async active-low reset
//   start_i       : load byte_i and raise we_o (1-cycle request)
//   byte_i        : byte to transmit
//   wait_i        : UART TX busy
//   we_o, di_o    : UART write strobe and data word ({24'b0, byte})
//   accept_o      : high in the cycle the write is accepted (we_o && !wait_i)
module uart_tx_holder (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [7:0]  byte_i,
    input  logic        wait_i,
    output logic        we_o,
    output logic [31:0] di_o,
    output logic        accept_o
);

    logic       we_q, we_d;
    logic [7:0] byte_q, byte_d;

    always_comb begin
        we_d   = we_q;
        byte_d = byte_q;
        if (start_i) begin
            we_d   = 1'b1;
            byte_d = byte_i;
        end else if (we_q && !wait_i) begin
            we_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q   <= 1'b0;
            byte_q <= 8'h00;
        end else begin
            we_q   <= we_d;
            byte_q <= byte_d;
        end
    end

    assign we_o     = we_q;
    assign di_o     = {24'h0, byte_q};
    assign accept_o = we_q && !wait_i;

endmodule

// File: rtl/uart_nand_cmd_bridge.sv
// ASCII command decoder between the simpleuart register port and nand_master.
// Each command byte (plus optional argument byte) yields exactly one TX byte.
//   hw_clk, resetn              : clock, async active-low reset
//   reg_dat_we/re/di/do/wait    : simpleuart register port
//   nand_cmd, nand_activate     : nand_master command and start pulse
//   nand_busy                   : nand_master busy
//   nand_data_in, nand_data_out : byte to / result byte from nand_master
//   led_rgb                     : {blue,green,red} LED enables
module uart_nand_cmd_bridge
    import uart_nand_pkg::*;
#(
    parameter int unsigned ARG_TIMEOUT  = 1200000,
    parameter int unsigned BUSY_TIMEOUT = 1200000,
    parameter int unsigned START_WIN    = 4
) (
    input  logic        hw_clk,
    input  logic        resetn,
    output logic        reg_dat_we,
    output logic        reg_dat_re,
    output logic [31:0] reg_dat_di,
    input  logic [31:0] reg_dat_do,
    input  logic        reg_dat_wait,
    output logic [5:0]  nand_cmd,
    output logic        nand_activate,
    input  logic        nand_busy,
    output logic [7:0]  nand_data_in,
    input  logic [7:0]  nand_data_out,
    output logic [2:0]  led_rgb
);

    localparam int unsigned MaxTo  = (ARG_TIMEOUT > BUSY_TIMEOUT) ? ARG_TIMEOUT : BUSY_TIMEOUT;
    localparam int unsigned CntMax = (MaxTo > START_WIN) ? MaxTo : START_WIN;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] ArgLast  = CntW'(ARG_TIMEOUT - 1);
    localparam logic [CntW-1:0] BusyLast = CntW'(BUSY_TIMEOUT - 1);
    localparam logic [CntW-1:0] WinLast  = CntW'(START_WIN - 1);

    state_e          state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      arg_q, arg_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]      nand_cmd_q, nand_cmd_d;
    logic [7:0]      data_in_q, data_in_d;
    logic [2:0]      led_q, led_d;

    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_accept;
    logic       rx_avail;

    assign rx_avail = (reg_dat_do != UART_EMPTY);

    uart_tx_holder u_tx_holder (
        .clk_i    (hw_clk),
        .rst_ni   (resetn),
        .start_i  (tx_start),
        .byte_i   (tx_byte),
        .wait_i   (reg_dat_wait),
        .we_o     (reg_dat_we),
        .di_o     (reg_dat_di),
        .accept_o (tx_accept)
    );

    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StBoot;
            cmd_q      <= 8'h00;
            arg_q      <= 8'h00;
            cnt_q      <= '0;
            nand_cmd_q <= 6'h00;
            data_in_q  <= 8'h00;
            led_q      <= 3'b010;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            cnt_q      <= cnt_d;
            nand_cmd_q <= nand_cmd_d;
            data_in_q  <= data_in_d;
            led_q      <= led_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        nand_cmd_d = nand_cmd_q;
        data_in_d  = data_in_q;
        led_d      = led_q;
        tx_start   = 1'b0;
        tx_byte    = RSP_Q;

        unique case (state_q)
            StBoot: begin
                tx_start = 1'b1;
                tx_byte  = RSP_P;
            end
            StIdle: begin
                if (rx_avail) begin
                    cmd_d   = reg_dat_do[7:0];
                    state_d = StRxPop;
                end
            end
            StRxPop: state_d = StDispatch;
            StDispatch: begin
                case (cmd_q)
                    CH_C: begin
                        if (nand_busy) begin
                            tx_start = 1'b1;
                            tx_byte  = RSP_B;
                        end else begin
                            state_d = StArgWait;
                        end
                    end
                    CH_D, CH_L: state_d = StArgWait;
                    CH_R: begin
                        tx_start = 1'b1;
                        tx_byte  = nand_data_out;
                    end
                    CH_S: begin
                        tx_start = 1'b1;
                        tx_byte  = RSP_ZERO + {7'b0, nand_busy};
                    end
                    default: tx_start = 1'b1;
                endcase
            end
            StArgWait: begin
                if (rx_avail) begin
                    arg_d   = reg_dat_do[7:0];
                    state_d = StArgPop;
                end else if (cnt_q == ArgLast) begin
                    tx_start = 1'b1;
                    tx_byte  = RSP_T;
                end
            end
            StArgPop: begin
                case (cmd_q)
                    CH_C: begin
                        if (arg_q[7:6] != 2'b00) begin
                            tx_start = 1'b1;
                        end else begin
                            nand_cmd_d = arg_q[5:0];
                            state_d    = StNandGo;
                        end
                    end
                    CH_D: begin
                        data_in_d = arg_q;
                        tx_start  = 1'b1;
                        tx_byte   = RSP_K;
                    end
                    CH_L: begin
                        tx_start = 1'b1;
                        if (is_led_digit(arg_q)) begin
                            led_d   = arg_q[2:0];
                            tx_byte = RSP_K;
                        end
                    end
                    default: tx_start = 1'b1;
                endcase
            end
            StNandGo: state_d = StNandHi;
            StNandHi: begin
                if (nand_busy) begin
                    state_d = StNandLo;
                end else if (cnt_q == WinLast) begin
                    // Busy never rose: assume a command that completed instantly.
                    tx_start = 1'b1;
                    tx_byte  = RSP_K;
                end
            end
            StNandLo: begin
                if (!nand_busy) begin
                    tx_start = 1'b1;
                    tx_byte  = RSP_K;
                end else if (cnt_q == BusyLast) begin
                    tx_start = 1'b1;
                    tx_byte  = RSP_E;
                end
            end
            StTx: begin
                if (tx_accept) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StBoot;
        endcase

        if (tx_start) begin
            state_d = StTx;
        end

        // Counter restarts on every state change and saturates otherwise.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != {CntW{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        reg_dat_re    = (state_q == StRxPop) || (state_q == StArgPop);
        nand_activate = (state_q == StNandGo);
        nand_cmd      = nand_cmd_q;
        nand_data_in  = data_in_q;
        led_rgb       = led_q;
    end

endmodule

// File: tb/tb_uart_nand_cmd_bridge.sv
// Directed bench: a negedge UART/NAND model feeds RX bytes, stalls TX via wait,
// records accepted TX bytes, and emulates nand_master busy after activate.
module tb_uart_nand_cmd_bridge;

    localparam int unsigned ArgTo    = 40;
    localparam int unsigned BusyTo   = 60;
    localparam int unsigned StartWin = 4;

    logic        hw_clk = 1'b0;
    logic        resetn = 1'b0;
    logic        reg_dat_we, reg_dat_re;
    logic [31:0] reg_dat_di;
    logic [31:0] reg_dat_do = 32'hFFFF_FFFF;
    logic        reg_dat_wait = 1'b0;
    logic [5:0]  nand_cmd;
    logic        nand_activate;
    logic        nand_busy = 1'b0;
    logic [7:0]  nand_data_in;
    logic [7:0]  nand_data_out = 8'h00;
    logic [2:0]  led_rgb;

    uart_nand_cmd_bridge #(
        .ARG_TIMEOUT  (ArgTo),
        .BUSY_TIMEOUT (BusyTo),
        .START_WIN    (StartWin)
    ) dut (
        .hw_clk        (hw_clk),
        .resetn        (resetn),
        .reg_dat_we    (reg_dat_we),
        .reg_dat_re    (reg_dat_re),
        .reg_dat_di    (reg_dat_di),
        .reg_dat_do    (reg_dat_do),
        .reg_dat_wait  (reg_dat_wait),
        .nand_cmd      (nand_cmd),
        .nand_activate (nand_activate),
        .nand_busy     (nand_busy),
        .nand_data_in  (nand_data_in),
        .nand_data_out (nand_data_out),
        .led_rgb       (led_rgb)
    );

    always #5 hw_clk = ~hw_clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int  wait_hold  = 3;
    int  hold_cnt   = 0;
    bit  prev_acc   = 1'b0;
    int  we_stuck   = 0;
    int  we_hi      = 0;
    int  act_cnt    = 0;
    int  busy_len   = 0;
    int  busy_timer = 0;
    bit  busy_force = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Environment model, driven on the falling edge so DUT sees stable inputs.
    always @(negedge hw_clk) begin
        if (reg_dat_re && rx_q.size() > 0) begin
            void'(rx_q.pop_front());
        end
        reg_dat_do = (rx_q.size() == 0) ? 32'hFFFF_FFFF : {24'h0, rx_q[0]};

        if (prev_acc && reg_dat_we) we_stuck++;
        prev_acc = 1'b0;
        if (reg_dat_we) begin
            we_hi++;
            if (hold_cnt < wait_hold) begin
                reg_dat_wait = 1'b1;
                hold_cnt++;
            end else begin
                reg_dat_wait = 1'b0;
                tx_q.push_back(reg_dat_di[7:0]);
                prev_acc = 1'b1;
                hold_cnt = 0;
            end
        end else begin
            reg_dat_wait = 1'b0;
            hold_cnt     = 0;
        end

        if (nand_activate) begin
            act_cnt++;
            busy_timer = busy_len;
        end else if (busy_timer != 0) begin
            busy_timer--;
        end
        nand_busy = busy_force || (busy_timer != 0);
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge hw_clk);
            #1;
        end
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] exp, output int waited);
        int n = 0;
        while (tx_q.size() == 0 && n < 400) begin
            step(1);
            n++;
        end
        waited = n;
        if (tx_q.size() == 0) check(tag, 32'hFFFF_FFFF, {24'h0, exp});
        else check(tag, {24'h0, tx_q.pop_front()}, {24'h0, exp});
    endtask

    task automatic cmd2(input logic [7:0] c, input logic [7:0] a);
        rx_q.push_back(c);
        rx_q.push_back(a);
    endtask

    initial begin
        int w;
        int act0;
        int we0;

        // Reset state.
        step(3);
        check("rst_we", reg_dat_we, 1'b0);
        check("rst_re", reg_dat_re, 1'b0);
        check("rst_di", reg_dat_di, 32'h0);
        check("rst_act", nand_activate, 1'b0);
        check("rst_cmd", nand_cmd, 6'h0);
        check("rst_din", nand_data_in, 8'h0);
        check("rst_led", led_rgb, 3'b010);

        // Boot 'P' with wait held 3 cycles.
        we0 = we_hi;
        resetn = 1'b1;
        expect_tx("boot_p", 8'h50, w);
        step(2);
        check("boot_we_cycles", we_hi - we0, 4);
        check("boot_we_low", reg_dat_we, 1'b0);
        check("boot_led", led_rgb, 3'b010);
        check("boot_single", tx_q.size(), 0);
        wait_hold = 1;

        // 'C' 05 with busy for 10 cycles.
        act0 = act_cnt;
        busy_len = 10;
        cmd2(8'h43, 8'h05);
        expect_tx("c05_k", 8'h4B, w);
        check("c05_cmd", nand_cmd, 6'h05);
        check("c05_act", act_cnt - act0, 1);

        // 'D' A5, then 'R' reading 3C.
        cmd2(8'h44, 8'hA5);
        expect_tx("d_k", 8'h4B, w);
        check("d_din", nand_data_in, 8'hA5);
        nand_data_out = 8'h3C;
        rx_q.push_back(8'h52);
        expect_tx("r_byte", 8'h3C, w);

        // Bad 'C' argument and LED settings.
        act0 = act_cnt;
        cmd2(8'h43, 8'h45);
        expect_tx("c45_q", 8'h3F, w);
        check("c45_act", act_cnt - act0, 0);
        cmd2(8'h4C, 8'h35);
        expect_tx("l5_k", 8'h4B, w);
        check("l5_led", led_rgb, 3'b101);
        cmd2(8'h4C, 8'h39);
        expect_tx("l9_q", 8'h3F, w);
        check("l9_led", led_rgb, 3'b101);

        // Status and unknown command.
        rx_q.push_back(8'h53);
        expect_tx("s_idle", 8'h30, w);
        rx_q.push_back(8'h58);
        expect_tx("unknown_q", 8'h3F, w);

        // Argument timeout.
        rx_q.push_back(8'h43);
        expect_tx("arg_t", 8'h54, w);
        check("arg_t_delay", (w >= 42 && w <= 50), 1'b1);

        // 'C' while busy.
        act0 = act_cnt;
        busy_force = 1'b1;
        step(2);
        cmd2(8'h43, 8'h01);
        expect_tx("c_busy_b", 8'h42, w);
        check("c_busy_act", act_cnt - act0, 0);
        busy_force = 1'b0;
        // Argument 01 stays queued and becomes an unknown command.
        expect_tx("c_busy_arg", 8'h3F, w);

        // Busy stuck high -> 'E', then 'S' reports busy.
        busy_len = 1000;
        cmd2(8'h43, 8'h02);
        expect_tx("busy_e", 8'h45, w);
        check("busy_e_delay", (w >= BusyTo && w <= BusyTo + 12), 1'b1);
        rx_q.push_back(8'h53);
        expect_tx("s_busy", 8'h31, w);
        for (int i = 0; i < 1200 && nand_busy; i++) step(1);
        check("busy_cleared", nand_busy, 1'b0);

        // Reset while in NAND_LO.
        act0 = act_cnt;
        cmd2(8'h43, 8'h07);
        for (int i = 0; i < 50 && act_cnt == act0; i++) step(1);
        check("lo_act_seen", act_cnt - act0, 1);
        step(5);
        resetn = 1'b0;
        #1;
        check("lo_rst_act", nand_activate, 1'b0);
        check("lo_rst_we", reg_dat_we, 1'b0);
        check("lo_rst_re", reg_dat_re, 1'b0);
        check("lo_rst_cmd", nand_cmd, 6'h0);
        check("lo_rst_led", led_rgb, 3'b010);
        step(2);
        check("lo_no_tx", tx_q.size(), 0);
        resetn = 1'b1;
        expect_tx("lo_p", 8'h50, w);

        // Reset while TX is held by wait.
        wait_hold = 20;
        rx_q.push_back(8'h53);
        for (int i = 0; i < 20 && !reg_dat_we; i++) step(1);
        step(3);
        check("tx_held_we", reg_dat_we, 1'b1);
        resetn = 1'b0;
        #1;
        check("tx_rst_we", reg_dat_we, 1'b0);
        step(2);
        wait_hold = 1;
        check("tx_no_accept", tx_q.size(), 0);
        resetn = 1'b1;
        expect_tx("tx_p", 8'h50, w);
        step(5);
        check("final_no_extra", tx_q.size(), 0);
        check("we_drop_after_accept", we_stuck, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
